// File: rtl/divisor_frecuencia_pkg.sv
// Shared constants for the programmable clock divider: default counter width
// and the setting that holds the divider stopped.
package divisor_frecuencia_pkg;

   localparam int DIV_W    = 11;
   localparam int DIV_STOP = 0;

endpackage : divisor_frecuencia_pkg

// File: rtl/divisor_contador.sv
// Half-period cycle counter: counts up to lim-1, then wraps and raises tc for
// one cycle. Held at zero while the limit is the stopped setting.
module divisor_contador
   import divisor_frecuencia_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] lim_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             stopped;

   assign stopped = (lim_i == WIDTH'(DIV_STOP));

   // >= rather than == so a limit lowered below the running count wraps on the
   // next edge instead of counting all the way around 2^WIDTH.
   assign tc_o = !stopped && (cnt_q >= (lim_i - WIDTH'(1)));

   always_comb begin
      cnt_d = cnt_q + WIDTH'(1);
      if (stopped || tc_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : divisor_contador

// File: rtl/divisor_frecuencia.sv
// Programmable 50% duty clock divider: clk_out toggles every `donde` clk
// cycles; donde=0 parks clk_out low.
module divisor_frecuencia
   import divisor_frecuencia_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] donde,
   output logic             clk_out
);

   logic [WIDTH-1:0] lim_q;
   logic [WIDTH-1:0] lim_d;
   logic             clk_out_q;
   logic             clk_out_d;
   logic             stopped;
   logic             tc;

   // The limit is registered so donde never reaches clk_out combinationally;
   // a new setting therefore acts one cycle after it is applied.
   assign lim_d   = donde;
   assign stopped = (lim_q == WIDTH'(DIV_STOP));

   divisor_contador #(
      .WIDTH (WIDTH)
   ) u_contador (
      .clk_i (clk),
      .rst_i (reset),
      .lim_i (lim_q),
      .tc_o  (tc)
   );

   always_comb begin
      clk_out_d = clk_out_q ^ tc;
      if (stopped) begin
         clk_out_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lim_q     <= '0;
         clk_out_q <= 1'b0;
      end else begin
         lim_q     <= lim_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign clk_out = clk_out_q;

endmodule : divisor_frecuencia

// File: tb/tb_divisor_frecuencia.sv
// Directed bench for divisor_frecuencia: reset, stop, divide ratios, mid-count
// limit change, boundary settings and asynchronous reset during operation.
module tb_divisor_frecuencia;

   localparam int W = 11;

   logic         clk;
   logic         reset;
   logic [W-1:0] donde;
   logic         clk_out;

   int vectors;
   int miscompares;

   logic [W-1:0] exp_q[$];

   divisor_frecuencia #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .donde   (donde),
      .clk_out (clk_out)
   );

   // 10 ns system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts falling edges until clk_out changes; -1 if budget runs out.
   task automatic wait_toggle(input int budget, output int cycles);
      logic prev;
      prev   = clk_out;
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (clk_out !== prev) begin
            cycles = i;
            break;
         end
      end
   endtask

   // Parks the divider with donde=0 so the next setting starts from phase 0.
   task automatic park;
      @(negedge clk);
      donde = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (clk_out !== 1'b0) begin
         miscompares++;
         $display("FAIL park: clk_out=%b required 0", clk_out);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      donde = W'(1666);
      #2;
      vectors++;
      if (clk_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async: clk_out=%b required 0", clk_out);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (clk_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_held: clk_out=%b required 0", clk_out);
      end
   endtask

   task automatic test_stop;
      int bad;
      bad   = 0;
      donde = '0;
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (clk_out !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stop_low: %0d cycles with clk_out high, required 0", bad);
      end
   endtask

   task automatic test_basic;
      int c;
      donde = W'(1666);
      wait_toggle(2000, c);
      vectors++;
      if (c !== 1667 || clk_out !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_first_rise: %0d cycles clk_out=%b, required 1667 and 1", c, clk_out);
      end
      wait_toggle(2000, c);
      vectors++;
      if (c !== 1666) begin
         miscompares++;
         $display("FAIL basic_high: %0d cycles, required 1666", c);
      end
      wait_toggle(2000, c);
      vectors++;
      if (c !== 1666) begin
         miscompares++;
         $display("FAIL basic_low: %0d cycles, required 1666", c);
      end
   endtask

   task automatic test_sweep;
      logic [W-1:0] n;
      int c_first, c_hi, c_lo;
      exp_q.push_back(W'(666));
      exp_q.push_back(W'(500));
      exp_q.push_back(W'(400));
      exp_q.push_back(W'(333));
      while (exp_q.size() > 0) begin
         n = exp_q.pop_front();
         park();
         donde = n;
         wait_toggle(1000, c_first);
         wait_toggle(1000, c_hi);
         wait_toggle(1000, c_lo);
         vectors++;
         if (c_first !== int'(n) + 1) begin
            miscompares++;
            $display("FAIL sweep_first_%0d: %0d cycles, required %0d", n, c_first, int'(n) + 1);
         end
         vectors++;
         if (c_hi + c_lo !== 2 * int'(n) || c_hi !== c_lo) begin
            miscompares++;
            $display("FAIL sweep_period_%0d: high %0d low %0d, required %0d each",
                     n, c_hi, c_lo, n);
         end
      end
   endtask

   task automatic test_decrease;
      int c;
      park();
      donde = W'(1666);
      wait_toggle(2000, c);
      repeat (1000) @(negedge clk);
      vectors++;
      if (clk_out !== 1'b1) begin
         miscompares++;
         $display("FAIL decrease_pre: clk_out=%b required 1", clk_out);
      end
      donde = W'(333);
      wait_toggle(2000, c);
      vectors++;
      if (c !== 2 || clk_out !== 1'b0) begin
         miscompares++;
         $display("FAIL decrease_toggle: %0d cycles clk_out=%b, required 2 and 0", c, clk_out);
      end
      for (int k = 0; k < 2; k++) begin
         wait_toggle(2000, c);
         vectors++;
         if (c !== 333) begin
            miscompares++;
            $display("FAIL decrease_half_%0d: %0d cycles, required 333", k, c);
         end
      end
   endtask

   task automatic test_boundaries;
      int c, c_hi, c_lo;
      park();
      donde = W'(1);
      wait_toggle(10, c);
      vectors++;
      if (c !== 2) begin
         miscompares++;
         $display("FAIL div1_first: %0d cycles, required 2", c);
      end
      for (int k = 0; k < 6; k++) begin
         wait_toggle(10, c);
         vectors++;
         if (c !== 1) begin
            miscompares++;
            $display("FAIL div1_half_%0d: %0d cycles, required 1", k, c);
         end
      end
      park();
      donde = W'(2047);
      wait_toggle(5000, c);
      vectors++;
      if (c !== 2048) begin
         miscompares++;
         $display("FAIL max_first: %0d cycles, required 2048", c);
      end
      wait_toggle(5000, c_hi);
      wait_toggle(5000, c_lo);
      vectors++;
      if (c_hi !== 2047 || c_lo !== 2047) begin
         miscompares++;
         $display("FAIL max_period: high %0d low %0d, required 2047 each", c_hi, c_lo);
      end
   endtask

   task automatic test_reset_mid;
      int c;
      park();
      donde = W'(50);
      wait_toggle(200, c);
      vectors++;
      if (clk_out !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_pre: clk_out=%b required 1", clk_out);
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (clk_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_async: clk_out=%b required 0", clk_out);
      end
      @(negedge clk);
      reset = 1'b0;
      wait_toggle(200, c);
      vectors++;
      if (c !== 51) begin
         miscompares++;
         $display("FAIL reset_mid_restart: %0d cycles, required 51", c);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      donde       = '0;
      test_reset();
      test_stop();
      test_basic();
      test_sweep();
      test_decrease();
      test_boundaries();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_divisor_frecuencia
